// File: rtl/memory_master.sv
// memory_master: valid/ready front end for a single-port synchronous memory,
// issuing single writes and incrementing burst reads with a back-pressured response.
module memory_master #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [2*WIDTH-1:0]   req_wdata,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2*WIDTH-1:0]   resp_rdata,
  output logic                 resp_last,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [2*WIDTH-1:0]   mem_wdata,
  input  logic [2*WIDTH-1:0]   mem_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RD_RESP} state_t;
  state_t r_state, w_state;
  logic [LEN_W-1:0] r_cnt, w_cnt;
  logic r_wr, w_wr, r_rd, w_rd, r_rv, w_rv, r_last, w_last;
  logic [WIDTH-1:0] r_addr, w_addr;
  logic [2*WIDTH-1:0] r_wdata, w_wdata, r_rdata, w_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_rv    <= 1'b0;
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_wr    <= w_wr;
      r_rd    <= w_rd;
      r_rv    <= w_rv;
      r_last  <= w_last;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_wr    = r_wr;
    w_rd    = r_rd;
    w_rv    = r_rv;
    w_last  = r_last;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    case (r_state)
      IDLE: if (req_valid) begin
        w_addr = req_addr;
        if (req_write) begin
          w_wr    = 1'b1;
          w_wdata = req_wdata;
          w_state = WR;
        end else begin
          w_rd    = 1'b1;
          w_cnt   = req_len;
          w_state = RD_ISSUE;
        end
      end
      WR: begin
        w_wr    = 1'b0;
        w_wdata = '0;
        w_state = IDLE;
      end
      RD_ISSUE: begin
        w_rd    = 1'b0;
        w_state = RD_CAPT;
      end
      RD_CAPT: begin
        w_rdata = mem_rdata;
        w_rv    = 1'b1;
        w_last  = (r_cnt == '0);
        w_state = RD_RESP;
      end
      RD_RESP: if (resp_ready) begin
        w_rv   = 1'b0;
        w_last = 1'b0;
        // next beat wraps the address naturally at 2^WIDTH
        if (r_cnt == '0) w_state = IDLE;
        else begin
          w_cnt   = r_cnt - 1'b1;
          w_addr  = r_addr + 1'b1;
          w_rd    = 1'b1;
          w_state = RD_ISSUE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_rv;
  assign resp_rdata = r_rdata;
  assign resp_last  = r_last;
  assign mem_write  = r_wr;
  assign mem_read   = r_rd;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
endmodule
